// File: rtl/fpnew_issue_ctrl.sv
// Issue/reorder controller in front of the FPNew FPU: tags each request with a ROB slot,
// collects out-of-order results and hands them back to the core in issue order.
module fpnew_issue_ctrl #(
  parameter int unsigned FLEN      = 64,
  parameter int unsigned TAG_WIDTH = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // core request side
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [3*FLEN-1:0]      req_operands_i,
  input  logic [2:0]             req_rnd_mode_i,
  input  logic [3:0]             req_op_i,
  input  logic                   req_op_mod_i,
  input  logic [2:0]             req_src_fmt_i,
  input  logic [2:0]             req_dst_fmt_i,
  input  logic [1:0]             req_int_fmt_i,
  input  logic                   req_vectorial_i,
  // FPU input handshake
  output logic [3*FLEN-1:0]      fpu_operands_o,
  output logic [2:0]             fpu_rnd_mode_o,
  output logic [3:0]             fpu_op_o,
  output logic                   fpu_op_mod_o,
  output logic [2:0]             fpu_src_fmt_o,
  output logic [2:0]             fpu_dst_fmt_o,
  output logic [1:0]             fpu_int_fmt_o,
  output logic                   fpu_vectorial_op_o,
  output logic [TAG_WIDTH:0]     fpu_tag_o,
  output logic                   fpu_in_valid_o,
  input  logic                   fpu_in_ready_i,
  output logic                   fpu_flush_o,
  // FPU output handshake
  input  logic [FLEN-1:0]        fpu_result_i,
  input  logic [4:0]             fpu_status_i,
  input  logic [TAG_WIDTH:0]     fpu_tag_i,
  input  logic                   fpu_out_valid_i,
  output logic                   fpu_out_ready_o,
  input  logic                   fpu_busy_i,
  // core flush and in-order response
  input  logic                   flush_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FLEN-1:0]        rsp_result_o,
  output logic [4:0]             rsp_status_o,
  output logic                   busy_o
);

  localparam int unsigned PTR_W = TAG_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** PTR_W;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]       state_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic [DEPTH-1:0] pending_q, done_q;
  logic [FLEN-1:0]  result_q [DEPTH];
  logic [4:0]       status_q [DEPTH];

  logic running, full, push, pop, complete;

  assign running  = (state_q == RUN);
  assign full     = (count_q == CNT_FULL);

  // Request fields go straight to the FPU; only the handshake is gated.
  assign fpu_operands_o     = req_operands_i;
  assign fpu_rnd_mode_o     = req_rnd_mode_i;
  assign fpu_op_o           = req_op_i;
  assign fpu_op_mod_o       = req_op_mod_i;
  assign fpu_src_fmt_o      = req_src_fmt_i;
  assign fpu_dst_fmt_o      = req_dst_fmt_i;
  assign fpu_int_fmt_o      = req_int_fmt_i;
  assign fpu_vectorial_op_o = req_vectorial_i;
  assign fpu_tag_o          = tail_q;

  assign fpu_in_valid_o  = running & req_valid_i & ~full & ~flush_i;
  assign req_ready_o     = running & fpu_in_ready_i & ~full & ~flush_i;
  assign push            = req_valid_i & req_ready_o;

  // Every issued op already owns a slot, so results are never back-pressured.
  assign fpu_out_ready_o = 1'b1;
  assign fpu_flush_o     = flush_i;
  assign complete        = running & ~flush_i & fpu_out_valid_i & pending_q[fpu_tag_i];

  assign rsp_valid_o  = running & done_q[head_q];
  assign rsp_result_o = result_q[head_q];
  assign rsp_status_o = status_q[head_q];
  assign pop          = rsp_valid_o & rsp_ready_i & ~flush_i;

  assign busy_o = (count_q != '0) | (state_q == DRAIN);

  // NOTE: all sequential state uses non-blocking assignments so every read in this
  // block sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else if (flush_i) begin
      state_q   <= DRAIN;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      done_q    <= '0;
    end else if (!running) begin
      if (!fpu_busy_i && !fpu_out_valid_i) state_q <= RUN;
    end else begin
      // Slots touched here never collide: a pushed slot is free, a completed slot is
      // pending, and the retired head is done.
      if (pop) begin
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + PTR_ONE;
      end
      if (complete) begin
        pending_q[fpu_tag_i] <= 1'b0;
        done_q[fpu_tag_i]    <= 1'b1;
      end
      if (push) begin
        pending_q[tail_q] <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        tail_q            <= tail_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the result/status storage is deliberately not reset; a slot is only read
  // once its done flag is set, and the flags themselves are reset above.
  always_ff @(posedge clk_i) begin
    if (complete) begin
      result_q[fpu_tag_i] <= fpu_result_i;
      status_q[fpu_tag_i] <= fpu_status_i;
    end
  end

  // A live result must always target a slot that is waiting for it.
  a_resp_to_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (running && !flush_i && fpu_out_valid_i) |-> pending_q[fpu_tag_i]);

endmodule

// File: tb/tb_fpnew_issue_ctrl.sv
// Self-checking bench for fpnew_issue_ctrl: directed scenarios followed by random traffic,
// all compared against an in-order queue model of the reorder buffer.
module tb_fpnew_issue_ctrl;
  localparam int FLEN  = 64;
  localparam int TW    = 1;
  localparam int DEPTH = 4;

  logic              clk, rst_n;
  logic              req_valid, req_ready, req_op_mod, req_vectorial;
  logic [3*FLEN-1:0] req_operands, fpu_operands;
  logic [2:0]        req_rnd_mode, req_src_fmt, req_dst_fmt, fpu_rnd_mode, fpu_src_fmt, fpu_dst_fmt;
  logic [3:0]        req_op, fpu_op;
  logic [1:0]        req_int_fmt, fpu_int_fmt;
  logic              fpu_op_mod, fpu_vectorial_op;
  logic [TW:0]       fpu_tag_out, fpu_tag_in;
  logic              fpu_in_valid, fpu_in_ready, fpu_flush;
  logic [FLEN-1:0]   fpu_result, rsp_result;
  logic [4:0]        fpu_status, rsp_status;
  logic              fpu_out_valid, fpu_out_ready, fpu_busy;
  logic              flush, rsp_valid, rsp_ready, busy;

  fpnew_issue_ctrl #(.FLEN(FLEN), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_rnd_mode_i(req_rnd_mode), .req_op_i(req_op), .req_op_mod_i(req_op_mod),
    .req_src_fmt_i(req_src_fmt), .req_dst_fmt_i(req_dst_fmt), .req_int_fmt_i(req_int_fmt),
    .req_vectorial_i(req_vectorial),
    .fpu_operands_o(fpu_operands), .fpu_rnd_mode_o(fpu_rnd_mode), .fpu_op_o(fpu_op),
    .fpu_op_mod_o(fpu_op_mod), .fpu_src_fmt_o(fpu_src_fmt), .fpu_dst_fmt_o(fpu_dst_fmt),
    .fpu_int_fmt_o(fpu_int_fmt), .fpu_vectorial_op_o(fpu_vectorial_op),
    .fpu_tag_o(fpu_tag_out), .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_flush_o(fpu_flush), .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
    .fpu_tag_i(fpu_tag_in), .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_busy_i(fpu_busy), .flush_i(flush), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: issue-order queue of slot tags plus per-slot bookkeeping.
  bit              m_drain;
  int              m_tail;
  int              rob_q[$];
  bit              m_pend [DEPTH];
  bit              m_done [DEPTH];
  logic [FLEN-1:0] m_res  [DEPTH];
  logic [4:0]      m_stat [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    rob_q.delete();
    m_tail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_pend[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic drive(input bit rv = 0, input bit ov = 0, input int otag = 0,
                       input logic [63:0] ores = 0, input logic [4:0] ost = 0,
                       input bit rr = 0, input bit fl = 0, input bit bz = 0);
    req_valid     = rv;
    req_operands  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_rnd_mode  = 3'($urandom);
    req_op        = 4'($urandom);
    req_op_mod    = 1'($urandom);
    req_src_fmt   = 3'($urandom);
    req_dst_fmt   = 3'($urandom);
    req_int_fmt   = 2'($urandom);
    req_vectorial = 1'($urandom);
    fpu_out_valid = ov;
    fpu_tag_in    = (TW + 1)'(otag);
    fpu_result    = ores;
    fpu_status    = ost;
    rsp_ready     = rr;
    flush         = fl;
    fpu_busy      = bz;
  endtask

  // Called at a falling edge with inputs applied: checks outputs, crosses one rising
  // edge, advances the model, and returns at the next falling edge.
  task automatic step();
    bit full, exp_iv, exp_rdy, exp_rv, passthru;
    int h;
    #1;
    full    = (rob_q.size() == DEPTH);
    exp_iv  = !m_drain && req_valid && !full && !flush;
    exp_rdy = !m_drain && fpu_in_ready && !full && !flush;
    exp_rv  = 1'b0;
    h       = 0;
    if (rob_q.size() > 0) begin
      h      = rob_q[0];
      exp_rv = !m_drain && m_done[h];
    end
    check("fpu_in_valid", fpu_in_valid, exp_iv);
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, exp_rv);
    check("busy", busy, (rob_q.size() != 0) || m_drain);
    check("fpu_flush", fpu_flush, flush);
    check("fpu_out_ready", fpu_out_ready, 1'b1);
    if (!m_drain) check("fpu_tag", fpu_tag_out, m_tail);
    if (exp_rv) begin
      check("rsp_result", rsp_result, m_res[h]);
      check("rsp_status", rsp_status, m_stat[h]);
    end
    passthru = (fpu_operands === req_operands) && (fpu_rnd_mode === req_rnd_mode) &&
               (fpu_op === req_op) && (fpu_op_mod === req_op_mod) &&
               (fpu_src_fmt === req_src_fmt) && (fpu_dst_fmt === req_dst_fmt) &&
               (fpu_int_fmt === req_int_fmt) && (fpu_vectorial_op === req_vectorial);
    check("passthrough", passthru, 1'b1);
    @(posedge clk);
    if (flush) begin
      model_clear();
      m_drain = 1'b1;
    end else if (m_drain) begin
      if (!fpu_busy && !fpu_out_valid) m_drain = 1'b0;
    end else begin
      if (exp_rv && rsp_ready) begin
        m_done[h] = 1'b0;
        void'(rob_q.pop_front());
      end
      if (fpu_out_valid && m_pend[int'(fpu_tag_in)]) begin
        m_pend[int'(fpu_tag_in)] = 1'b0;
        m_done[int'(fpu_tag_in)] = 1'b1;
        m_res[int'(fpu_tag_in)]  = fpu_result;
        m_stat[int'(fpu_tag_in)] = fpu_status;
      end
      if (exp_iv && exp_rdy) begin
        rob_q.push_back(m_tail);
        m_pend[m_tail] = 1'b1;
        m_done[m_tail] = 1'b0;
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    @(negedge clk);
  endtask

  function automatic int pick_pending();
    int cand[$];
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) cand.push_back(i);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  // Return all outstanding results in random order and retire them, within a bound.
  task automatic settle();
    int t, budget;
    budget = 60;
    while (rob_q.size() > 0 && budget > 0) begin
      t = pick_pending();
      if (t >= 0) drive(.ov(1), .otag(t), .ores({$urandom, $urandom}), .ost(5'($urandom)), .rr(1));
      else        drive(.rr(1));
      step();
      budget--;
    end
    check("settle_empty", rob_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold_res;
    logic [4:0]  hold_st;
    int t;

    model_clear();
    m_drain      = 1'b0;
    fpu_in_ready = 1'b0;
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_ready", fpu_out_ready, 1'b1);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_in_valid", fpu_in_valid, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    fpu_in_ready = 1'b1;

    // Single FADD: tag 0, result back after a few idle cycles, retired one cycle later.
    drive(.rv(1));
    req_op = 4'd2;
    step();
    for (int i = 0; i < 3; i++) begin drive(); step(); end
    drive(.ov(1), .otag(0), .ores(64'h4000_0000_0000_0000), .ost(5'd0));
    step();
    drive(.rr(1));
    #1;
    check("single_rsp_result", rsp_result, 64'h4000_0000_0000_0000);
    step();
    drive(.rr(1));
    step();
    check("single_busy_after", busy, 1'b0);

    // Out-of-order completion 2,0,1 with in-order release.
    for (int i = 0; i < 3; i++) begin drive(.rv(1), .rr(1)); step(); end
    drive(.ov(1), .otag(rob_q[2]), .ores(64'hAAAA_0002), .ost(5'h02), .rr(1)); step();
    drive(.rr(1)); step();
    drive(.ov(1), .otag(rob_q[0]), .ores(64'hAAAA_0000), .ost(5'h10), .rr(1)); step();
    drive(.ov(1), .otag(rob_q[1]), .ores(64'hAAAA_0001), .ost(5'h01), .rr(1)); step();
    for (int i = 0; i < 3; i++) begin drive(.rr(1)); step(); end
    check("ooo_empty", rob_q.size(), 0);

    // Full ROB: fifth request blocked until a retire, then issues into the wrapped slot.
    for (int i = 0; i < 4; i++) begin drive(.rv(1)); step(); end
    drive(.rv(1)); step();
    drive(.rv(1), .ov(1), .otag(rob_q[0]), .ores(64'h1234_5678), .ost(5'h04)); step();
    drive(.rv(1), .rr(1)); step();
    drive(.rv(1)); step();
    check("full_wrap_count", rob_q.size(), DEPTH);
    settle();

    // Response backpressure: two done slots held for ten cycles, then back-to-back retire.
    for (int i = 0; i < 2; i++) begin drive(.rv(1)); step(); end
    drive(.ov(1), .otag(rob_q[1]), .ores(64'hBEEF_0001), .ost(5'h08)); step();
    drive(.ov(1), .otag(rob_q[0]), .ores(64'hBEEF_0000), .ost(5'h03)); step();
    hold_res = rsp_result;
    hold_st  = rsp_status;
    for (int i = 0; i < 10; i++) begin drive(); step(); end
    check("bp_hold_result", rsp_result, hold_res);
    check("bp_hold_status", rsp_status, hold_st);
    drive(.rr(1)); step();
    drive(.rr(1)); step();
    check("bp_retired", rob_q.size(), 0);

    // Flush with three outstanding, stale response during drain, then restart at tag 0.
    for (int i = 0; i < 3; i++) begin drive(.rv(1)); step(); end
    drive(.rv(1), .fl(1), .bz(1)); step();
    drive(.rv(1), .ov(1), .otag(1), .ores(64'hDEAD), .rr(1), .bz(1)); step();
    drive(.rv(1), .rr(1), .bz(1)); step();
    drive(.rv(1), .rr(1), .fl(1), .bz(1)); step();
    drive(.rr(1), .bz(0)); step();
    drive(.rv(1), .rr(1)); step();
    for (int i = 0; i < 3; i++) begin drive(.rr(1)); step(); end
    settle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      fpu_in_ready = 1'($urandom_range(3) != 0);
      t = pick_pending();
      drive(.rv($urandom_range(1)),
            .ov((t >= 0 && $urandom_range(1) == 1) || (m_drain && $urandom_range(3) == 0)),
            .otag(t >= 0 ? t : int'($urandom_range(DEPTH - 1))),
            .ores({$urandom, $urandom}), .ost(5'($urandom)),
            .rr($urandom_range(3) != 0), .fl($urandom_range(39) == 0),
            .bz(m_drain && $urandom_range(1) == 1));
      step();
    end
    fpu_in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(.rr(1)); step(); end
    settle();

    // Asynchronous reset with two outstanding operations.
    for (int i = 0; i < 2; i++) begin drive(.rv(1)); step(); end
    drive();
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_tag", fpu_tag_out, 0);
    check("arst_out_ready", fpu_out_ready, 1'b1);
    model_clear();
    m_drain = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(); step();
    drive(.rv(1)); step();
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
